// File: rtl/bitcoin_nonce_scheduler.sv
// Bitcoin nonce sweep sequencer for one shared SHA-256 compression core.
// Block 1 is hashed once per job; blocks 2 and 3 repeat for every nonce.
module bitcoin_nonce_scheduler #(
  parameter int NUM_NONCES = 16,
  localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [18:0][31:0]   header,
  input  logic [31:0]         nonce_base,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  output logic [IW-1:0]       out_idx,
  output logic [31:0]         out_h0,
  output logic                core_start,
  output logic [15:0][31:0]   core_message,
  output logic [7:0][31:0]    core_in,
  input  logic                core_done,
  input  logic [7:0][31:0]    core_hash
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] B1_GO   = 4'd1;
  localparam logic [3:0] B1_WAIT = 4'd2;
  localparam logic [3:0] B2_GO   = 4'd3;
  localparam logic [3:0] B2_WAIT = 4'd4;
  localparam logic [3:0] B3_GO   = 4'd5;
  localparam logic [3:0] B3_WAIT = 4'd6;
  localparam logic [3:0] EMIT    = 4'd7;
  localparam logic [3:0] DONE    = 4'd8;

  localparam logic [IW-1:0] LAST = IW'(NUM_NONCES - 1);

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic [3:0]         state;
  logic [IW-1:0]      idx;
  logic [31:0]        nonce_r;
  logic [7:0][31:0]   midstate;

  // Tail of the 80-byte header plus padding for a 640-bit message
  function automatic logic [15:0][31:0] blk2(
    input logic [18:0][31:0] h,
    input logic [31:0]       n
  );
    logic [15:0][31:0] m;
    m     = '0;
    m[0]  = h[16];
    m[1]  = h[17];
    m[2]  = h[18];
    m[3]  = n;
    m[4]  = 32'h80000000;
    m[15] = 32'd640;
    return m;
  endfunction

  // First digest padded as a 256-bit message
  function automatic logic [15:0][31:0] blk3(
    input logic [7:0][31:0] d
  );
    logic [15:0][31:0] m;
    m      = '0;
    m[7:0] = d;
    m[8]   = 32'h80000000;
    m[15]  = 32'd256;
    return m;
  endfunction

  assign core_start = (state == B1_GO) ||
                      (state == B2_GO) ||
                      (state == B3_GO);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign out_valid  = (state == EMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      out_idx <= '0;
      out_h0  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            nonce_r      <= nonce_base;
            idx          <= '0;
            core_message <= header[15:0];
            core_in      <= IV;
            state        <= B1_GO;
          end
        end
        B1_GO: state <= B1_WAIT;
        B1_WAIT: begin
          if (core_done) begin
            midstate     <= core_hash;
            core_in      <= core_hash;
            core_message <= blk2(header, nonce_r + 32'(idx));
            state        <= B2_GO;
          end
        end
        B2_GO: state <= B2_WAIT;
        B2_WAIT: begin
          if (core_done) begin
            core_in      <= IV;
            core_message <= blk3(core_hash);
            state        <= B3_GO;
          end
        end
        B3_GO: state <= B3_WAIT;
        B3_WAIT: begin
          if (core_done) begin
            out_h0  <= core_hash[0];
            out_idx <= idx;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx          <= idx + 1'b1;
            core_in      <= midstate;
            core_message <= blk2(header, nonce_r + 32'(idx) + 32'd1);
            state        <= B2_GO;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_nonce_scheduler.sv
// Bench for bitcoin_nonce_scheduler: SHA-256 core model plus a byte-level
// double-SHA-256 reference of each 80-byte header.
module tb_bitcoin_nonce_scheduler;

  localparam int N  = 16;
  localparam int IW = 4;

  localparam logic [7:0][31:0] SHA_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [18:0][31:0] header;
  logic [31:0]       nonce_base;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic [IW-1:0]     out_idx;
  logic [31:0]       out_h0;
  logic              core_start;
  logic [15:0][31:0] core_message;
  logic [7:0][31:0]  core_in;
  logic              core_done = 1'b0;
  logic [7:0][31:0]  core_hash = '0;

  bitcoin_nonce_scheduler #(.NUM_NONCES(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .header       (header),
    .nonce_base   (nonce_base),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .out_h0       (out_h0),
    .core_start   (core_start),
    .core_message (core_message),
    .core_in      (core_in),
    .core_done    (core_done),
    .core_hash    (core_hash)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  int done_cnt  = 0;
  int n_cdone   = 0;
  int exp_idx   = 0;
  int lat_cnt   = 0;
  int fixed_lat = 0;

  logic              waiting = 1'b0;
  logic              prev_start = 1'b0;
  logic [7:0][31:0]  pend;
  logic [7:0][31:0]  snap_in;
  logic [15:0][31:0] snap_m;
  logic [7:0][31:0]  job_mid;
  logic [18:0][31:0] job_hdr;
  logic [31:0]       job_base;
  logic [31:0]       exp_h0 [N];
  logic [31:0]       obs_h0 [N];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] sha_compress(
    input logic [7:0][31:0]  h,
    input logic [15:0][31:0] m
  );
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    a = h[0]; b = h[1]; c = h[2]; d = h[3];
    e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
         + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  function automatic logic [7:0][31:0] sha256_bytes(input logic [7:0] msg [$]);
    logic [7:0]        p [$];
    logic [63:0]       bits;
    logic [15:0][31:0] m;
    logic [7:0][31:0]  h;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    h = SHA_IV;
    for (int bk = 0; bk < p.size() / 64; bk++) begin
      for (int w = 0; w < 16; w++)
        m[w] = {p[64*bk+4*w], p[64*bk+4*w+1], p[64*bk+4*w+2], p[64*bk+4*w+3]};
      h = sha_compress(h, m);
    end
    return h;
  endfunction

  // Word 0 of SHA256(SHA256(80-byte header)), nonce appended big-endian
  function automatic logic [31:0] ref_h0(
    input logic [18:0][31:0] h,
    input logic [31:0]       n
  );
    logic [7:0]       bs [$];
    logic [7:0][31:0] d;
    for (int i = 0; i < 19; i++)
      for (int j = 3; j >= 0; j--) bs.push_back(h[i][8*j +: 8]);
    for (int j = 3; j >= 0; j--) bs.push_back(n[8*j +: 8]);
    d = sha256_bytes(bs);
    bs.delete();
    for (int i = 0; i < 8; i++)
      for (int j = 3; j >= 0; j--) bs.push_back(d[i][8*j +: 8]);
    d = sha256_bytes(bs);
    return d[0];
  endfunction

  // Core model and protocol monitor
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        core_done = 1'b1;
        core_hash = pend;
        n_cdone++;
      end
    end
    if (core_start) begin
      pend = sha_compress(core_in, core_message);
      lat_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
    if (!busy) waiting = 1'b0;
    if (waiting && !core_start) begin
      for (int w = 0; w < 16; w++) check("msg_hold", core_message[w], snap_m[w]);
      for (int w = 0; w < 8; w++) check("in_hold", core_in[w], snap_in[w]);
    end
    if (core_done) waiting = 1'b0;
    if (core_start) begin
      check("start_1cyc", 32'(prev_start), 32'd0);
      if (start_cnt == 0) begin
        for (int w = 0; w < 16; w++) check("b1_msg", core_message[w], job_hdr[w]);
        check("b1_in", core_in[0], SHA_IV[0]);
      end else if (start_cnt % 2 == 1) begin
        check("b2_nonce", core_message[3], job_base + 32'((start_cnt - 1) / 2));
        check("b2_w0", core_message[0], job_hdr[16]);
        check("b2_pad", core_message[4], 32'h80000000);
        check("b2_len", core_message[15], 32'd640);
        check("b2_in", core_in[0], job_mid[0]);
      end else begin
        check("b3_pad", core_message[8], 32'h80000000);
        check("b3_len", core_message[15], 32'd256);
        check("b3_in", core_in[0], SHA_IV[0]);
      end
      snap_m  = core_message;
      snap_in = core_in;
      waiting = 1'b1;
      start_cnt++;
    end
    if (out_valid) begin
      check("out_idx", 32'(out_idx), 32'(exp_idx));
      if (exp_idx < N) check("out_h0", out_h0, exp_h0[exp_idx]);
      obs_h0[out_idx] = out_h0;
      exp_idx++;
      valid_cnt++;
    end
    if (done) begin
      done_cnt++;
      check("done_busy", 32'(busy), 32'd0);
    end
    prev_start = core_start;
  end

  task automatic prep(input logic [18:0][31:0] h, input logic [31:0] base);
    job_hdr  = h;
    job_base = base;
    job_mid  = sha_compress(SHA_IV, h[15:0]);
    for (int i = 0; i < N; i++) exp_h0[i] = ref_h0(h, base + 32'(i));
    start_cnt = 0;
    valid_cnt = 0;
    done_cnt  = 0;
    exp_idx   = 0;
  endtask

  task automatic kick();
    @(negedge clk);
    header     = job_hdr;
    nonce_base = job_base;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    nonce_base = $urandom;
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic finish_job(input bit inj);
    int cyc;
    cyc = 0;
    fork
      begin
        while (done_cnt == 0 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
        end
      end
      begin
        if (inj) begin
          int c;
          c = 0;
          while (start_cnt < 2 && c < 3000) begin @(negedge clk); c++; end
          @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          c = 0;
          while (valid_cnt < 1 && c < 3000) begin @(negedge clk); c++; end
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    check("job_timeout", 32'(cyc < 3000), 32'd1);
    repeat (6) @(negedge clk);
    check("core_starts", 32'(start_cnt), 32'(1 + 2 * N));
    check("out_valids", 32'(valid_cnt), 32'(N));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_job(
    input logic [18:0][31:0] h,
    input logic [31:0]       base,
    input bit                inj
  );
    prep(h, base);
    kick();
    finish_job(inj);
  endtask

  function automatic logic [18:0][31:0] rand_hdr();
    logic [18:0][31:0] h;
    for (int i = 0; i < 19; i++) h[i] = $urandom;
    return h;
  endfunction

  logic [18:0][31:0] gen_hdr;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    header     = '0;
    nonce_base = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cstart", 32'(core_start), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_h0", out_h0, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job('0, 32'd0, 1'b0);

    gen_hdr     = '0;
    gen_hdr[0]  = 32'h01000000;
    gen_hdr[9]  = 32'h3ba3edfd;
    gen_hdr[10] = 32'h7a7b12b2;
    gen_hdr[11] = 32'h7ac72c3e;
    gen_hdr[12] = 32'h67768f61;
    gen_hdr[13] = 32'h7fc81bc3;
    gen_hdr[14] = 32'h888a5132;
    gen_hdr[15] = 32'h3a9fb8aa;
    gen_hdr[16] = 32'h4b1e5e4a;
    gen_hdr[17] = 32'h29ab5f49;
    gen_hdr[18] = 32'hffff001d;
    run_job(gen_hdr, 32'h1dac2b79, 1'b0);
    check("genesis_h0", obs_h0[3], 32'h6fe28c0a);

    run_job(rand_hdr(), 32'hfffffffe, 1'b0);
    run_job(rand_hdr(), $urandom, 1'b1);

    // Abort mid-job with a long core latency so a stray done follows
    fixed_lat = 8;
    prep(rand_hdr(), $urandom);
    kick();
    begin
      int c;
      int s0;
      int v0;
      int d0;
      c = 0;
      while (start_cnt < 3 && c < 3000) begin @(negedge clk); c++; end
      check("b3_reached", 32'(start_cnt), 32'd3);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      s0 = start_cnt;
      v0 = valid_cnt;
      d0 = n_cdone;
      check("abort_h0", out_h0, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (15) @(negedge clk);
      check("stray_done", 32'(n_cdone - d0), 32'd1);
      check("abort_starts", 32'(start_cnt), 32'(s0));
      check("abort_valids", 32'(valid_cnt), 32'(v0));
      check("abort_dones", 32'(done_cnt), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    fixed_lat = 0;

    run_job(rand_hdr(), $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
